// File: rtl/addsub_acc.sv
// addsub_acc: registered add/subtract unit with optional running accumulator.
// Valid/ready handshake on both sides; one-stage output register, full throughput.
// Optional feature macro: ADDSUB_ACC_SAT_EN (saturate accumulate-mode results).
module addsub_acc #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             Clk_in,
  input  logic             Rst_in,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  input  logic             Sel_in,
  input  logic             Acc_in,
  input  logic             Clr_in,
  input  logic             Valid_in,
  output logic             Ready_out,
  output logic [WIDTH:0]   Rez_out,
  output logic             Ovf_out,
  output logic             Valid_out,
  input  logic             Ready_in
);

  localparam int unsigned RW = WIDTH + 1;
  localparam int unsigned XW = WIDTH + 2;

  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [RW-1:0] acc_q, acc_d;
  logic [RW-1:0] rez_q, rez_d;
  logic          ovf_q, ovf_d;

  logic          accept;
  logic          drain;
  logic [RW-1:0] op_x;
  logic [XW-1:0] raw;
  logic [RW-1:0] res;
  logic          res_ovf;

  assign Valid_out = (state_q == S_FULL);
  assign Rez_out   = rez_q;
  assign Ovf_out   = ovf_q;
  // A new result may be taken whenever the output slot is empty or is draining now.
  assign Ready_out = !Valid_out || Ready_in;
  assign accept    = Valid_in && Ready_out;
  assign drain     = Valid_out && Ready_in;

  // Arithmetic: a same-cycle clear zeroes the accumulator operand before use.
  always_comb begin
    op_x    = '0;
    raw     = '0;
    res     = '0;
    res_ovf = 1'b0;
    if (Acc_in) begin
      op_x = Clr_in ? '0 : acc_q;
    end else begin
      op_x = RW'(A_in);
    end
    if (Sel_in) begin
      raw = XW'(op_x) - XW'(B_in);
    end else begin
      raw = XW'(op_x) + XW'(B_in);
    end
    res     = raw[RW-1:0];
    res_ovf = Acc_in && raw[XW-1];
`ifdef ADDSUB_ACC_SAT_EN
    if (res_ovf) begin
      res = Sel_in ? '0 : '1;
    end
`endif
  end

  // Next-state for output-slot FSM, result register and accumulator.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rez_d   = rez_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_EMPTY: begin
        if (accept) begin
          state_d = S_FULL;
        end
      end
      S_FULL: begin
        if (accept) begin
          state_d = S_FULL;
        end else if (drain) begin
          state_d = S_EMPTY;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    if (accept) begin
      rez_d = res;
      ovf_d = res_ovf;
      acc_d = res;
    end else if (Clr_in) begin
      acc_d = '0;
    end
  end

  // State register with synchronous reset that overrides every other input.
  always_ff @(posedge Clk_in) begin
    if (Rst_in) begin
      state_q <= S_EMPTY;
      acc_q   <= '0;
      rez_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rez_q   <= rez_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_addsub_acc.sv
// Self-checking bench for addsub_acc (WIDTH=8), directed scenarios plus random traffic.
module tb_addsub_acc;

  localparam int W   = 8;
  localparam int MOD = 1 << (W + 1);

  logic         Clk_in = 1'b0;
  logic         Rst_in = 1'b1;
  logic [W-1:0] A_in = '0;
  logic [W-1:0] B_in = '0;
  logic         Sel_in = 1'b0;
  logic         Acc_in = 1'b0;
  logic         Clr_in = 1'b0;
  logic         Valid_in = 1'b0;
  logic         Ready_out;
  logic [W:0]   Rez_out;
  logic         Ovf_out;
  logic         Valid_out;
  logic         Ready_in = 1'b0;

  int n_total = 0;
  int n_pass  = 0;

  // reference model state
  int acc_m = 0;
  int rez_m = 0;
  bit ovf_m = 1'b0;
  bit vld_m = 1'b0;
  bit rdy_obs, rdy_exp;

  addsub_acc #(.WIDTH(W)) dut (
    .Clk_in(Clk_in), .Rst_in(Rst_in), .A_in(A_in), .B_in(B_in),
    .Sel_in(Sel_in), .Acc_in(Acc_in), .Clr_in(Clr_in), .Valid_in(Valid_in),
    .Ready_out(Ready_out), .Rez_out(Rez_out), .Ovf_out(Ovf_out),
    .Valid_out(Valid_out), .Ready_in(Ready_in)
  );

  always #5 Clk_in = ~Clk_in;

`ifdef ADDSUB_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  // Apply one cycle of inputs, sample Ready_out before the edge, advance the model.
  task automatic drive(input bit v, input int a, input int b, input bit s,
                       input bit ac, input bit cl, input bit rd, input bit rs = 1'b0);
    int x, r, res;
    bit ovf, acc_ok;
    Valid_in = v; A_in = a[W-1:0]; B_in = b[W-1:0]; Sel_in = s;
    Acc_in = ac; Clr_in = cl; Ready_in = rd; Rst_in = rs;
    #1;
    rdy_obs = Ready_out;
    rdy_exp = !vld_m || rd;
    @(posedge Clk_in);
    acc_ok = v && (!vld_m || rd);
    if (rs) begin
      acc_m = 0; rez_m = 0; ovf_m = 0; vld_m = 0;
    end else if (acc_ok) begin
      x   = ac ? (cl ? 0 : acc_m) : (a % (1 << W));
      r   = s ? x - (b % (1 << W)) : x + (b % (1 << W));
      ovf = ac && (r < 0 || r >= MOD);
      res = ((r % MOD) + MOD) % MOD;
      if (SAT && ovf) res = s ? 0 : MOD - 1;
      rez_m = res; ovf_m = ovf; acc_m = res; vld_m = 1;
    end else begin
      if (cl) acc_m = 0;
      if (vld_m && rd) vld_m = 0;
    end
    #1;
  endtask

  task automatic test_reset;
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    Rst_in = 1'b0;
    #1;
    n_total++;
    if ({Valid_out, Ovf_out, Rez_out, Ready_out} !== {1'b0, 1'b0, 9'd0, 1'b1})
      $display("FAIL reset: got v=%0b o=%0b r=%0d rdy=%0b exp v=0 o=0 r=0 rdy=1",
               Valid_out, Ovf_out, Rez_out, Ready_out);
    else n_pass++;
  endtask

  task automatic test_direct_add;
    drive(1, 200, 100, 0, 0, 0, 1);
    n_total++;
    if ({Valid_out, Ovf_out, Rez_out} !== {1'b1, 1'b0, 9'h12C})
      $display("FAIL direct_add: got v=%0b o=%0b r=%0d exp v=1 o=0 r=300", Valid_out, Ovf_out, Rez_out);
    else n_pass++;
  endtask

  task automatic test_direct_sub;
    drive(1, 5, 10, 1, 0, 0, 1);
    n_total++;
    if ({Valid_out, Ovf_out, Rez_out} !== {1'b1, 1'b0, 9'h1FB})
      $display("FAIL direct_sub_neg: got v=%0b o=%0b r=%0h exp v=1 o=0 r=1fb", Valid_out, Ovf_out, Rez_out);
    else n_pass++;
    drive(1, 10, 5, 1, 0, 0, 1);
    n_total++;
    if ({Valid_out, Ovf_out, Rez_out} !== {1'b1, 1'b0, 9'd5})
      $display("FAIL direct_sub_pos: got v=%0b o=%0b r=%0d exp v=1 o=0 r=5", Valid_out, Ovf_out, Rez_out);
    else n_pass++;
  endtask

  task automatic test_backpressure;
    drive(0, 0, 0, 0, 0, 0, 1);
    drive(1, 1, 1, 0, 0, 0, 0);
    n_total++;
    if ({Valid_out, Rez_out} !== {1'b1, 9'd2})
      $display("FAIL bp_first: got v=%0b r=%0d exp v=1 r=2", Valid_out, Rez_out);
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      drive(1, 2, 2, 0, 0, 0, 0);
      n_total++;
      if ({rdy_obs, Valid_out, Rez_out} !== {1'b0, 1'b1, 9'd2})
        $display("FAIL bp_hold: got rdy=%0b v=%0b r=%0d exp rdy=0 v=1 r=2", rdy_obs, Valid_out, Rez_out);
      else n_pass++;
    end
    drive(1, 2, 2, 0, 0, 0, 1);
    n_total++;
    if ({rdy_obs, Valid_out, Rez_out} !== {1'b1, 1'b1, 9'd4})
      $display("FAIL bp_release: got rdy=%0b v=%0b r=%0d exp rdy=1 v=1 r=4", rdy_obs, Valid_out, Rez_out);
    else n_pass++;
    drive(0, 0, 0, 0, 0, 0, 1);
    n_total++;
    if (Valid_out !== 1'b0)
      $display("FAIL bp_no_dup: got v=%0b exp v=0", Valid_out);
    else n_pass++;
  endtask

  task automatic test_acc_add;
    int exp_r [3];
    bit exp_o [3];
    exp_r = '{200, 400, SAT ? 511 : 88};
    exp_o = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 200, 0, 1, (i == 0), 1);
      n_total++;
      if ({Valid_out, Ovf_out, Rez_out} !== {1'b1, exp_o[i], 9'(exp_r[i])})
        $display("FAIL acc_add[%0d]: got v=%0b o=%0b r=%0d exp v=1 o=%0b r=%0d",
                 i, Valid_out, Ovf_out, Rez_out, exp_o[i], exp_r[i]);
      else n_pass++;
    end
  endtask

  task automatic test_acc_sub;
    int exp_r;
    drive(1, 10, 0, 0, 0, 0, 1);
    drive(1, 0, 20, 1, 1, 0, 1);
    exp_r = SAT ? 0 : 502;
    n_total++;
    if ({Valid_out, Ovf_out, Rez_out} !== {1'b1, 1'b1, 9'(exp_r)})
      $display("FAIL acc_sub: got v=%0b o=%0b r=%0d exp v=1 o=1 r=%0d", Valid_out, Ovf_out, Rez_out, exp_r);
    else n_pass++;
    drive(1, 0, 7, 0, 1, 1, 1);
    n_total++;
    if ({Valid_out, Ovf_out, Rez_out} !== {1'b1, 1'b0, 9'd7})
      $display("FAIL acc_clr_same: got v=%0b o=%0b r=%0d exp v=1 o=0 r=7", Valid_out, Ovf_out, Rez_out);
    else n_pass++;
    // clear without accept leaves the held result intact
    drive(0, 0, 0, 0, 0, 1, 0);
    n_total++;
    if ({Valid_out, Rez_out} !== {1'b1, 9'd7})
      $display("FAIL clr_hold: got v=%0b r=%0d exp v=1 r=7", Valid_out, Rez_out);
    else n_pass++;
    drive(1, 0, 1, 0, 1, 0, 1);
    n_total++;
    if ({Valid_out, Ovf_out, Rez_out} !== {1'b1, 1'b0, 9'd1})
      $display("FAIL clr_alone: got v=%0b o=%0b r=%0d exp v=1 o=0 r=1", Valid_out, Ovf_out, Rez_out);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    drive(0, 0, 0, 0, 0, 0, 1);
    drive(1, 0, 50, 0, 1, 0, 0);
    n_total++;
    if ({Valid_out, Rez_out} !== {1'b1, 9'd51})
      $display("FAIL rst_mid_pre: got v=%0b r=%0d exp v=1 r=51", Valid_out, Rez_out);
    else n_pass++;
    drive(1, 9, 9, 0, 0, 1, 1, 1);
    n_total++;
    if ({Valid_out, Ovf_out, Rez_out, Ready_out} !== {1'b0, 1'b0, 9'd0, 1'b1})
      $display("FAIL rst_mid: got v=%0b o=%0b r=%0d rdy=%0b exp v=0 o=0 r=0 rdy=1",
               Valid_out, Ovf_out, Rez_out, Ready_out);
    else n_pass++;
    drive(1, 0, 3, 0, 1, 0, 1);
    n_total++;
    if ({Valid_out, Ovf_out, Rez_out} !== {1'b1, 1'b0, 9'd3})
      $display("FAIL rst_mid_post: got v=%0b o=%0b r=%0d exp v=1 o=0 r=3", Valid_out, Ovf_out, Rez_out);
    else n_pass++;
  endtask

  task automatic test_random;
    int errs = 0;
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0);
      n_total++;
      if (rdy_obs !== rdy_exp || Valid_out !== vld_m ||
          (vld_m && (Rez_out !== 9'(rez_m) || Ovf_out !== ovf_m))) begin
        if (errs < 10)
          $display("FAIL random[%0d]: got rdy=%0b v=%0b o=%0b r=%0d exp rdy=%0b v=%0b o=%0b r=%0d",
                   i, rdy_obs, Valid_out, Ovf_out, Rez_out, rdy_exp, vld_m, ovf_m, rez_m);
        errs++;
      end else n_pass++;
    end
    Rst_in = 1'b0;
  endtask

  initial begin
    test_reset();
    test_direct_add();
    test_direct_sub();
    test_backpressure();
    test_acc_add();
    test_acc_sub();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
